// File: rtl/mod_reduce_8bit.sv
// Unsigned 8-bit modular reduction: restoring division producing a mod n and floor(a/n).
// Eight RUN steps per reduction, with a one-cycle error path for a zero modulus.

module comp_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       gt,
   output logic       eq,
   output logic       lt
);
   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);
endmodule

module mod_reduce_8bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] n,
   output logic       busy,
   output logic       done,
   output logic [7:0] r,
   output logic [7:0] q,
   output logic       err
);
   localparam int unsigned W  = 8;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nx;
   logic [W:0]     p, p_nx;
   logic [W-1:0]   qr, qr_nx;
   logic [W-1:0]   nl, nl_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [W-1:0]   r_nx, q_nx;
   logic           err_nx, busy_nx, done_nx;

   logic [W:0]     p_sh;
   logic [W:0]     diff;
   logic           cmp_gt, cmp_eq, cmp_lt;
   logic           ge;

   // One left shift of {P,Q}; the comparator only sees the low byte since P[8] forces a subtract.
   assign p_sh = {p[W-1:0], qr[W-1]};
   assign diff = p_sh - {1'b0, nl};
   assign ge   = p_sh[W] | cmp_gt | cmp_eq;

   comp_8bit u_comp (
      .a  (p_sh[W-1:0]),
      .b  (nl),
      .gt (cmp_gt),
      .eq (cmp_eq),
      .lt (cmp_lt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         p     <= '0;
         qr    <= '0;
         nl    <= '0;
         cnt   <= '0;
         r     <= '0;
         q     <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         p     <= p_nx;
         qr    <= qr_nx;
         nl    <= nl_nx;
         cnt   <= cnt_nx;
         r     <= r_nx;
         q     <= q_nx;
         err   <= err_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      p_nx     = p;
      qr_nx    = qr;
      nl_nx    = nl;
      cnt_nx   = cnt;
      r_nx     = r;
      q_nx     = q;
      err_nx   = err;
      busy_nx  = busy;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               busy_nx = 1'b1;
               if (n != '0) begin
                  nl_nx    = n;
                  p_nx     = '0;
                  qr_nx    = a;
                  cnt_nx   = '0;
                  state_nx = RUN;
               end else begin
                  r_nx     = a;
                  q_nx     = 8'hFF;
                  err_nx   = 1'b1;
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end
            end
         end
         RUN: begin
            p_nx   = ge ? diff : p_sh;
            qr_nx  = {qr[W-2:0], ge};
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
               r_nx     = p_nx[W-1:0];
               q_nx     = qr_nx;
               err_nx   = 1'b0;
               done_nx  = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mod_reduce_8bit.sv
// Self-checking bench for mod_reduce_8bit: directed cases, zero modulus, back-to-back starts,
// mid-run reset abort and randomized operands against an arithmetic reference.

module tb_mod_reduce_8bit;
   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, n;
   logic       busy, done, err;
   logic [7:0] r, q;

   int vectors   = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mod_reduce_8bit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .n     (n),
      .busy  (busy),
      .done  (done),
      .r     (r),
      .q     (q),
      .err   (err)
   );

   // Reference: plain integer division; zero modulus reports a unchanged, all-ones quotient.
   function automatic void model(input int ma, input int mn, output int eq, output int er,
                                 output int ee, output int elat);
      if (mn == 0) begin
         eq = 255; er = ma; ee = 1; elat = 1;
      end else begin
         eq = ma / mn; er = ma % mn; ee = 0; elat = 9;
      end
   endfunction

   // Launches one reduction and waits (bounded) for done; lat = cycles from start cycle to done cycle.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tn, input bit scramble,
                        output int lat, output int bcnt);
      @(negedge clk);
      a = ta; n = tn; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 20) begin
         if (scramble) begin a = 8'($urandom); n = 8'($urandom); start = 1'($urandom); end
         bcnt += int'(busy);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (done) bcnt += int'(busy);
      else lat = -1;
   endtask

   task automatic check_op(input string tag, input int ta, input int tn, input bit scramble);
      int lat, bcnt, eq, er, ee, elat;
      model(ta, tn, eq, er, ee, elat);
      do_op(8'(ta), 8'(tn), scramble, lat, bcnt);
      vectors++;
      if (lat != elat || int'(q) != eq || int'(r) != er || int'(err) != ee) begin
         miscompares++;
         $display("FAIL %s a=%0d n=%0d: got lat=%0d q=%0d r=%0d err=%0d, want lat=%0d q=%0d r=%0d err=%0d",
                  tag, ta, tn, lat, q, r, err, elat, eq, er, ee);
      end
      vectors++;
      if (lat > 0 && bcnt != elat) begin
         miscompares++;
         $display("FAIL %s_busy a=%0d n=%0d: busy cycles %0d want %0d", tag, ta, tn, bcnt, elat);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; a = 8'd200; n = 8'd7;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, err, r, q} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset: busy=%b done=%b err=%b r=%0d q=%0d want all zero", busy, done, err, r, q);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_directed;
      check_op("d200_7", 200, 7, 1'b0);
      check_op("d5_13", 5, 13, 1'b0);
      check_op("d15_15", 15, 15, 1'b0);
      check_op("d255_1", 255, 1, 1'b0);
      check_op("d0_1", 0, 1, 1'b0);
      check_op("d255_255", 255, 255, 1'b0);
      check_op("d254_255", 254, 255, 1'b0);
      check_op("d255_128", 255, 128, 1'b0);
      // done must be a single-cycle pulse, results held afterwards
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 8'd1 || r !== 8'd127) begin
         miscompares++;
         $display("FAIL pulse_hold: done=%b busy=%b q=%0d r=%0d want 0 0 1 127", done, busy, q, r);
      end
   endtask

   task automatic test_zero_modulus;
      check_op("z77_0", 77, 0, 1'b0);
      check_op("z9_4", 9, 4, 1'b0);
      check_op("z0_0", 0, 0, 1'b0);
      check_op("z255_0", 255, 0, 1'b0);
      check_op("z8_3", 8, 3, 1'b0);
   endtask

   task automatic test_scramble;
      for (int i = 0; i < 40; i++) check_op("scramble", int'($urandom_range(0, 255)),
                                            int'($urandom_range(0, 255)), 1'b1);
   endtask

   task automatic test_back_to_back;
      int cyc, last, pulses;
      @(negedge clk);
      a = 8'd100; n = 8'd9; start = 1'b1;
      last = -1; pulses = 0;
      for (cyc = 0; cyc < 62; cyc++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            vectors++;
            if (q !== 8'd11 || r !== 8'd1 || err !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_value: q=%0d r=%0d err=%b want 11 1 0", q, r, err);
            end
            if (last >= 0) begin
               vectors++;
               if (cyc - last != 10) begin
                  miscompares++;
                  $display("FAIL b2b_spacing: %0d cycles want 10", cyc - last);
               end
            end
            last = cyc;
            a = 8'd100; n = 8'd9;
         end else if (busy) begin
            a = 8'($urandom); n = 8'($urandom);
         end
      end
      start = 1'b0;
      vectors++;
      if (pulses != 6) begin
         miscompares++;
         $display("FAIL b2b_count: %0d pulses want 6", pulses);
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_abort;
      int seen;
      @(negedge clk);
      a = 8'd250; n = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({busy, done, err, r, q} !== 19'd0) begin
         miscompares++;
         $display("FAIL abort_state: busy=%b done=%b err=%b r=%0d q=%0d want all zero", busy, done, err, r, q);
      end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL abort_quiet: %0d active cycles after abort want 0", seen);
      end
      check_op("abort_rerun", 250, 3, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 1500; i++) begin
         int ra, rn;
         ra = int'($urandom_range(0, 255));
         rn = (i % 8 == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 255));
         check_op("rand", ra, rn, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; n = '0;
      test_reset;
      test_directed;
      test_zero_modulus;
      test_back_to_back;
      test_abort;
      test_scramble;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
